fault_mem_cfg: RTL and testbench

Parametrised, run-time configurable faulty SRAM model used as the device-under-test for the MBIST controller and march-algorithm benches. It replaces the per-fault hard-coded memory variants with one block. A single victim cell and bit, plus an optional aggressor cell, receive one of seven classic fault models, selected through ports. The block keeps a registered command stage, a registered read pipeline and a fault-activation counter, so the BIST logic can cross-check its detection against ground truth.

---
 rtl/fault_mem_cfg.sv | 150 +++++++++++++++
 tb/tb_fault_mem_cfg.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_mem_cfg.sv
// Configurable faulty SRAM: registered command stage, one access stage and one output
// stage, with a single victim bit carrying one of seven fault models.
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [2:0]            fault_type,
  input  logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic [BW-1:0]         fault_bit,
  input  logic [ADDR_WIDTH-1:0] aggr_addr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic [CNT_WIDTH-1:0]  fault_cnt
);

  typedef enum logic [2:0] {
    FT_NONE, FT_SA0, FT_SA1, FT_TFD, FT_TFU, FT_CFIN, FT_CFID, FT_RDF
  } fault_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [2:0]            ftype;
    logic [ADDR_WIDTH-1:0] faddr;
    logic [BW-1:0]         fbit;
    logic [ADDR_WIDTH-1:0] aaddr;
  } cmd_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  cmd_t                  cmd_q;
  logic [2:0]            vld_pipe;   // [0] command stage, [1] rd_q, [2] rdata
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vic_init;

  fault_e                ft;
  logic                  in_rng, fa_in, aa_in, is_vic, cf_ok;
  logic [DATA_WIDTH-1:0] old_w, vic_w, a_data, v_data, rd_d;
  logic                  a_we, v_we, hit, vic_set;

  assign ft     = fault_e'(cmd_q.ftype);
  assign in_rng = {1'b0, cmd_q.addr}  < DEPTH_L;
  assign fa_in  = {1'b0, cmd_q.faddr} < DEPTH_L;
  assign aa_in  = {1'b0, cmd_q.aaddr} < DEPTH_L;
  assign is_vic = in_rng && (cmd_q.addr == cmd_q.faddr);
  // Coupling faults need a distinct, in-range aggressor and a victim with a known value.
  assign cf_ok  = (ft == FT_CFIN || ft == FT_CFID) && vic_init && fa_in && aa_in &&
                  (cmd_q.aaddr != cmd_q.faddr) && (cmd_q.addr == cmd_q.aaddr);

  always_comb begin
    old_w   = in_rng ? mem[cmd_q.addr]  : '0;
    vic_w   = fa_in  ? mem[cmd_q.faddr] : '0;
    a_we    = 1'b0;
    a_data  = cmd_q.wdata;
    v_we    = 1'b0;
    v_data  = vic_w;
    rd_d    = '0;
    hit     = 1'b0;
    vic_set = 1'b0;
    if (vld_pipe[0] && in_rng) begin
      if (cmd_q.we) begin
        a_we = 1'b1;
        if (is_vic) begin
          vic_set = 1'b1;
          if (vic_init && ft == FT_TFD && old_w[cmd_q.fbit] && !cmd_q.wdata[cmd_q.fbit]) begin
            a_data[cmd_q.fbit] = 1'b1;
            hit                = 1'b1;
          end
          if (vic_init && ft == FT_TFU && !old_w[cmd_q.fbit] && cmd_q.wdata[cmd_q.fbit]) begin
            a_data[cmd_q.fbit] = 1'b0;
            hit                = 1'b1;
          end
        end
        if (cf_ok && ft == FT_CFIN && (old_w[cmd_q.fbit] != cmd_q.wdata[cmd_q.fbit])) begin
          v_we               = 1'b1;
          v_data[cmd_q.fbit] = ~vic_w[cmd_q.fbit];
          hit                = 1'b1;
        end
        if (cf_ok && ft == FT_CFID && !old_w[cmd_q.fbit] && cmd_q.wdata[cmd_q.fbit] &&
            !vic_w[cmd_q.fbit]) begin
          v_we               = 1'b1;
          v_data[cmd_q.fbit] = 1'b1;
          hit                = 1'b1;
        end
      end else begin
        rd_d = old_w;
        if (is_vic) begin
          case (ft)
            FT_SA0: begin
              rd_d[cmd_q.fbit] = 1'b0;
              hit              = old_w[cmd_q.fbit];
            end
            FT_SA1: begin
              rd_d[cmd_q.fbit] = 1'b1;
              hit              = ~old_w[cmd_q.fbit];
            end
            FT_RDF: begin
              // Destructive read: the inverted bit is also written back.
              rd_d[cmd_q.fbit] = ~old_w[cmd_q.fbit];
              a_we             = 1'b1;
              a_data           = rd_d;
              hit              = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Array is deliberately unreset; a dropped command never raises a_we/v_we.
  always_ff @(posedge clk) begin
    if (a_we) mem[cmd_q.addr]  <= a_data;
    if (v_we) mem[cmd_q.faddr] <= v_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      cmd_q     <= '0;
      rd_q      <= '0;
      rdata     <= '0;
      vic_init  <= 1'b0;
      fault_cnt <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], vld_pipe[0] & ~cmd_q.we, cs};
      if (cs) cmd_q <= '{we: write_read, addr: address, wdata: wdata, ftype: fault_type,
                         faddr: fault_addr, fbit: fault_bit, aaddr: aggr_addr};
      if (vld_pipe[0] && !cmd_q.we) rd_q <= rd_d;
      if (vld_pipe[1]) rdata <= rd_q;
      if (vic_set) vic_init <= 1'b1;
      if (hit && fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
    end
  end

  assign rdata_valid = vld_pipe[2];

endmodule

// File: tb/tb_fault_mem_cfg.sv
// Bench for fault_mem_cfg: two instances (16 words/16-bit counter, 12 words/2-bit counter)
// share stimulus and are checked against a per-command behavioural memory model.
module tb_fault_mem_cfg;
  logic       clk = 1'b0, rst_n = 1'b0, cs = 1'b0, write_read = 1'b0;
  logic [3:0] address = '0, fault_addr = '0, aggr_addr = '0;
  logic [7:0] wdata = '0;
  logic [2:0] fault_type = '0, fault_bit = '0;
  logic [7:0] rdata_a, rdata_b;
  logic       rv_a, rv_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  fault_mem_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .write_read(write_read), .address(address),
    .wdata(wdata), .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .aggr_addr(aggr_addr), .rdata(rdata_a), .rdata_valid(rv_a), .fault_cnt(cnt_a));

  fault_mem_cfg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(12), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .write_read(write_read), .address(address),
    .wdata(wdata), .fault_type(fault_type), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .aggr_addr(aggr_addr), .rdata(rdata_b), .rdata_valid(rv_b), .fault_cnt(cnt_b));

  // Reference model: one memory image per instance, updated a whole command at a time.
  logic [7:0] mm [2][16];
  bit         vinit [2];
  int         cnt [2];
  int         dep [2]  = '{16, 12};
  int         cmax [2] = '{65535, 3};
  bit         res_v [2];
  logic [7:0] res_d [2];
  bit         exp_v [2];
  logic [7:0] exp_d [2];
  int         exp_c [2];
  bit         p_cs, p_we;
  int         p_a, p_ft, p_fa, p_fb, p_ag;
  logic [7:0] p_d;

  task automatic bump(input int k);
    if (cnt[k] < cmax[k]) cnt[k]++;
  endtask

  task automatic model_access(input int k);
    logic [7:0] old, nw;
    res_v[k] = 0; res_d[k] = '0;
    if (!p_cs) return;
    if (!p_we) begin
      res_v[k] = 1;
      if (p_a >= dep[k]) return;
      old = mm[k][p_a]; nw = old;
      if (p_a == p_fa) begin
        if (p_ft == 1) begin if (old[p_fb]) bump(k); nw[p_fb] = 1'b0; end
        else if (p_ft == 2) begin if (!old[p_fb]) bump(k); nw[p_fb] = 1'b1; end
        else if (p_ft == 7) begin nw[p_fb] = ~old[p_fb]; mm[k][p_a] = nw; bump(k); end
      end
      res_d[k] = nw;
    end else if (p_a < dep[k]) begin
      old = mm[k][p_a]; nw = p_d;
      if (p_a == p_fa) begin
        if (vinit[k] && p_ft == 3 && old[p_fb] && !nw[p_fb]) begin nw[p_fb] = 1'b1; bump(k); end
        if (vinit[k] && p_ft == 4 && !old[p_fb] && nw[p_fb]) begin nw[p_fb] = 1'b0; bump(k); end
        vinit[k] = 1;
      end
      mm[k][p_a] = nw;
      if ((p_ft == 5 || p_ft == 6) && vinit[k] && p_a == p_ag && p_ag != p_fa && p_fa < dep[k]) begin
        if (p_ft == 5 && old[p_fb] != nw[p_fb]) begin
          mm[k][p_fa][p_fb] = ~mm[k][p_fa][p_fb]; bump(k);
        end
        if (p_ft == 6 && !old[p_fb] && nw[p_fb] && !mm[k][p_fa][p_fb]) begin
          mm[k][p_fa][p_fb] = 1'b1; bump(k);
        end
      end
    end
  endtask

  // Drive one command (or idle), clock it, and advance the model by one edge.
  task automatic step(input bit c, input bit w, input int a, input logic [7:0] d);
    cs = c; write_read = w; address = 4'(a); wdata = d;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      exp_v[k] = res_v[k]; exp_d[k] = res_d[k];
      model_access(k);
      exp_c[k] = cnt[k];
    end
    p_cs = c; p_we = w; p_a = a; p_d = d;
    p_ft = int'(fault_type); p_fa = int'(fault_addr); p_fb = int'(fault_bit); p_ag = int'(aggr_addr);
    cs = 1'b0;
  endtask

  task automatic clear_model();
    p_cs = 0;
    for (int k = 0; k < 2; k++) begin
      res_v[k] = 0; vinit[k] = 0; cnt[k] = 0; exp_v[k] = 0; exp_c[k] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear_model();
    repeat (2) step(0, 0, 0, 8'h00);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic set_fault(input int ft, input int fa, input int fb, input int ag);
    fault_type = 3'(ft); fault_addr = 4'(fa); fault_bit = 3'(fb); aggr_addr = 4'(ag);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_model();
    repeat (2) step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b0 || rdata_a !== 8'h00 || cnt_a !== 16'd0) begin
      failures++;
      $display("FAIL reset_a: valid=%0b rdata=%h cnt=%0d required 0/00/0", rv_a, rdata_a, cnt_a);
    end
    checks++;
    if (rv_b !== 1'b0 || rdata_b !== 8'h00 || cnt_b !== 2'd0) begin
      failures++;
      $display("FAIL reset_b: valid=%0b rdata=%h cnt=%0d required 0/00/0", rv_b, rdata_b, cnt_b);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    do_reset(); set_fault(0, 0, 0, 0);
    for (int a = 0; a < 16; a++) step(1, 1, a, 8'(a * 17));
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 0, (i < 16) ? i : 0, 8'h00);
      checks++;
      if (i < 2) begin
        if (rv_a !== 1'b0) begin
          failures++; $display("FAIL ideal_lead step %0d: valid=%0b required 0", i, rv_a);
        end
      end else if (rv_a !== 1'b1 || rdata_a !== 8'((i - 2) * 17)) begin
        failures++;
        $display("FAIL ideal_a addr %0d: valid=%0b rdata=%h required 1/%h", i - 2, rv_a, rdata_a, 8'((i - 2) * 17));
      end
      if (i >= 2) begin
        checks++;
        if (rv_b !== 1'b1 || rdata_b !== ((i - 2 < 12) ? 8'((i - 2) * 17) : 8'h00)) begin
          failures++;
          $display("FAIL ideal_b addr %0d: valid=%0b rdata=%h", i - 2, rv_b, rdata_b);
        end
      end
    end
    // Single read: invisible one edge after capture, visible for exactly one cycle after two.
    step(1, 0, 3, 8'h00);
    step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b0) begin failures++; $display("FAIL latency_early: valid=%0b required 0", rv_a); end
    step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'h33) begin
      failures++; $display("FAIL latency_hit: valid=%0b rdata=%h required 1/33", rv_a, rdata_a);
    end
    step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b0 || cnt_a !== 16'd0) begin
      failures++; $display("FAIL latency_late: valid=%0b cnt=%0d required 0/0", rv_a, cnt_a);
    end
  endtask

  task automatic test_sa1();
    do_reset(); set_fault(2, 5, 4, 0);
    step(1, 1, 5, 8'h00); step(1, 0, 5, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'h10 || cnt_a !== 16'd1) begin
      failures++; $display("FAIL sa1_zero: valid=%0b rdata=%h cnt=%0d required 1/10/1", rv_a, rdata_a, cnt_a);
    end
    step(1, 1, 5, 8'hFF); step(1, 0, 5, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'hFF || cnt_a !== 16'd1) begin
      failures++; $display("FAIL sa1_ones: valid=%0b rdata=%h cnt=%0d required 1/ff/1", rv_a, rdata_a, cnt_a);
    end
  endtask

  task automatic test_tf_down();
    do_reset(); set_fault(3, 5, 4, 0);
    step(1, 1, 5, 8'hFF); step(1, 1, 5, 8'h00); step(1, 0, 5, 8'h00);
    step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h10 || cnt_a !== 16'd1) begin
      failures++; $display("FAIL tfd: rdata=%h cnt=%0d required 10/1", rdata_a, cnt_a);
    end
    do_reset();
    step(1, 1, 5, 8'h00); step(1, 0, 5, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h00 || cnt_a !== 16'd0) begin
      failures++; $display("FAIL tfd_noinit: rdata=%h cnt=%0d required 00/0", rdata_a, cnt_a);
    end
  endtask

  task automatic test_cf();
    do_reset(); set_fault(5, 5, 4, 9);
    step(1, 1, 9, 8'h00); step(1, 1, 5, 8'h00); step(1, 1, 9, 8'h00); step(1, 1, 9, 8'h10);
    step(1, 0, 5, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h10 || cnt_a !== 16'd1) begin
      failures++; $display("FAIL cfin_once: rdata=%h cnt=%0d required 10/1", rdata_a, cnt_a);
    end
    step(1, 1, 9, 8'h00); step(1, 0, 5, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h00 || cnt_a !== 16'd2) begin
      failures++; $display("FAIL cfin_twice: rdata=%h cnt=%0d required 00/2", rdata_a, cnt_a);
    end
    do_reset(); set_fault(5, 5, 4, 5);
    step(1, 1, 5, 8'h00); step(1, 1, 5, 8'h10); step(1, 0, 5, 8'h00);
    step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h10 || cnt_a !== 16'd0) begin
      failures++; $display("FAIL cfin_self: rdata=%h cnt=%0d required 10/0", rdata_a, cnt_a);
    end
    do_reset(); set_fault(6, 5, 4, 9);
    step(1, 1, 9, 8'h00); step(1, 1, 5, 8'h00); step(1, 1, 9, 8'h10);
    step(1, 1, 9, 8'h00); step(1, 1, 9, 8'h10); step(1, 0, 5, 8'h00);
    step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'h10 || cnt_a !== 16'd1) begin
      failures++; $display("FAIL cfid: rdata=%h cnt=%0d required 10/1", rdata_a, cnt_a);
    end
  endtask

  task automatic test_rdf_oor();
    do_reset(); set_fault(7, 3, 0, 0);
    step(1, 1, 3, 8'h00); step(1, 0, 3, 8'h00); step(1, 0, 3, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'h01) begin
      failures++; $display("FAIL rdf_first: valid=%0b rdata=%h required 1/01", rv_a, rdata_a);
    end
    step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'h00 || cnt_a !== 16'd2) begin
      failures++; $display("FAIL rdf_second: valid=%0b rdata=%h cnt=%0d required 1/00/2", rv_a, rdata_a, cnt_a);
    end
    repeat (4) step(1, 0, 3, 8'h00);
    step(0, 0, 0, 8'h00);
    checks++;
    if (cnt_a !== 16'd6 || cnt_b !== 2'd3) begin
      failures++; $display("FAIL saturate: cnt_a=%0d cnt_b=%0d required 6/3", cnt_a, cnt_b);
    end
    step(1, 1, 14, 8'h5A); step(1, 0, 14, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rv_b !== 1'b1 || rdata_b !== 8'h00 || rv_a !== 1'b1 || rdata_a !== 8'h5A) begin
      failures++;
      $display("FAIL oor: b valid=%0b rdata=%h required 1/00, a valid=%0b rdata=%h required 1/5a", rv_b, rdata_b, rv_a, rdata_a);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); set_fault(1, 2, 0, 0);
    step(1, 1, 2, 8'hA5); step(1, 0, 2, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rdata_a !== 8'hA4 || cnt_a !== 16'd1) begin
      failures++; $display("FAIL mid_pre: rdata=%h cnt=%0d required a4/1", rdata_a, cnt_a);
    end
    step(1, 1, 2, 8'h3C);
    rst_n = 1'b0; clear_model();
    step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b0 || rdata_a !== 8'h00 || cnt_a !== 16'd0) begin
      failures++; $display("FAIL mid_in_reset: valid=%0b rdata=%h cnt=%0d required 0/00/0", rv_a, rdata_a, cnt_a);
    end
    @(negedge clk); rst_n = 1'b1;
    set_fault(0, 0, 0, 0);
    step(1, 0, 2, 8'h00); step(0, 0, 0, 8'h00); step(0, 0, 0, 8'h00);
    checks++;
    if (rv_a !== 1'b1 || rdata_a !== 8'hA5) begin
      failures++; $display("FAIL mid_dropped: valid=%0b rdata=%h required 1/a5", rv_a, rdata_a);
    end
  endtask

  task automatic test_random();
    int fa, ag, a, sel;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      fa = $urandom_range(0, 15);
      ag = ($urandom_range(0, 4) == 0) ? fa : $urandom_range(0, 15);
      set_fault(0, fa, $urandom_range(0, 7), ag);
      for (int i = 0; i < 16; i++) step(1, 1, i, 8'($urandom));
      fault_type = 3'($urandom_range(0, 7));
      for (int i = 0; i < 90; i++) begin
        if ($urandom_range(0, 15) == 0) begin
          fault_type = 3'($urandom_range(0, 7)); fault_bit = 3'($urandom_range(0, 7));
        end
        sel = $urandom_range(0, 3);
        a = (sel == 0) ? fa : (sel == 1) ? ag : $urandom_range(0, 15);
        if (i < 88) step($urandom_range(0, 3) != 0, $urandom_range(0, 1), a, 8'($urandom));
        else step(0, 0, 0, 8'h00);
        checks++;
        if (rv_a !== exp_v[0] || (exp_v[0] && rdata_a !== exp_d[0]) || cnt_a !== 16'(exp_c[0])) begin
          failures++;
          $display("FAIL rand_a r%0d i%0d: valid=%0b rdata=%h cnt=%0d required %0b/%h/%0d",
                   r, i, rv_a, rdata_a, cnt_a, exp_v[0], exp_d[0], exp_c[0]);
        end
        checks++;
        if (rv_b !== exp_v[1] || (exp_v[1] && rdata_b !== exp_d[1]) || cnt_b !== 2'(exp_c[1])) begin
          failures++;
          $display("FAIL rand_b r%0d i%0d: valid=%0b rdata=%h cnt=%0d required %0b/%h/%0d",
                   r, i, rv_b, rdata_b, cnt_b, exp_v[1], exp_d[1], exp_c[1]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ideal();
    test_sa1();
    test_tf_down();
    test_cf();
    test_rdf_oor();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
